wptr_full_lvl: RTL and testbench

//  Write-domain pointer/flag block for the async FIFO. Successor to the basic write-pointer/full logic.
//  - Keeps the binary and Gray (GRAYSTYLE2) write pointers and the write-side full flag.
//  - Adds a registered fill level (wlevel) and an almost-full flag with a runtime threshold.
//  - Sits between the write client, the FIFO memory (waddr) and the rptr->wclk 2-FF synchroniser (wq2_rptr).

---
 rtl/fifo_ptr_pkg.sv | 34 +++
 rtl/wptr_full_lvl_gray2bin.sv | 26 ++
 rtl/wptr_full_lvl.sv | 138 +++++++++++++
 tb/tb_wptr_full_lvl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg
//   Shared pointer helpers for the async FIFO pointer/flag blocks
//   (wptr_full_lvl, rptr_empty_lvl).
//
//   Contents:
//     PTR_W_MAX     widest supported pointer (ADDRSIZE max 12, plus wrap bit)
//     DEPTH         FIFO depth for the default address width
//     bin2gray()    binary -> Gray, on PTR_W_MAX-bit vectors
//     gray2bin()    Gray -> binary, on PTR_W_MAX-bit vectors
//
//   Both helpers work on zero-extended vectors. Leading zeros are a fixed
//   point of both conversions, so any pointer of ADDRSIZE+1 bits can be
//   widened, converted and sliced back without changing its value.
package fifo_ptr_pkg;

  localparam int unsigned ADDRSIZE_MAX  = 12;
  localparam int unsigned PTR_W_MAX     = ADDRSIZE_MAX + 1;
  localparam int unsigned ADDRSIZE_DFLT = 4;
  localparam int unsigned DEPTH         = 2 ** ADDRSIZE_DFLT;

  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] v);
    return (v >> 1) ^ v;
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] v);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = v[PTR_W_MAX-1];
    for (int unsigned i = PTR_W_MAX - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ v[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl_gray2bin.sv
// gray2bin
//   Purely combinational Gray -> binary converter (XOR prefix from the MSB
//   down). Shared by the write-side and read-side pointer blocks.
//
//   Parameters:
//     WIDTH   vector width
//   Ports:
//     gray_i  in   WIDTH   Gray-coded value
//     bin_o   out  WIDTH   binary equivalent
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o          = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    // bin[i] = XOR of gray[WIDTH-1:i]; walk down reusing the bit above.
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      bin_o[i-1] = bin_o[i] ^ gray_i[i-1];
    end
  end

endmodule

// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl
//   Write-domain pointer/flag block for the async FIFO. Holds the binary and
//   Gray write pointers and the zero-latency full flag, plus a registered
//   fill level and an almost-full flag against a runtime threshold.
//
//   Parameters:
//     ADDRSIZE      memory address width, depth = 2**ADDRSIZE (2..12)
//     AFULL_RST     reset value of walmost_full
//
//   Ports:
//     wclk          in   write clock, rising edge
//     wrst_n        in   asynchronous active-low reset
//     winc          in   write request, accepted only while wfull==0
//     wq2_rptr      in   Gray read pointer, already synchronised to wclk
//     afull_thresh  in   almost-full threshold in words (0..2**ADDRSIZE)
//     waddr         out  memory write address (binary pointer LSBs)
//     wptr          out  registered Gray write pointer to the rclk syncer
//     wfull         out  registered full flag
//     walmost_full  out  registered (wlevel >= afull_thresh)
//     wlevel        out  registered words stored, seen from the write side
//     wovf          out  sticky write-while-full flag
//
//   Build option:
//     WPTR_FULL_OVF_EN  when defined, wovf is a sticky flop set by a write
//                       attempt while full; otherwise wovf is tied low.
module wptr_full_lvl
  import fifo_ptr_pkg::PTR_W_MAX;
  import fifo_ptr_pkg::bin2gray;
#(
  parameter int unsigned ADDRSIZE  = 4,
  parameter bit          AFULL_RST = 1'b0
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  // State registers
  logic [ADDRSIZE:0]   wbin_q;
  logic [ADDRSIZE:0]   wptr_q;
  logic                wfull_q;
  logic                walmost_full_q;
  logic [ADDRSIZE:0]   wlevel_q;

  // Next-state values
  logic                wen;
  logic [ADDRSIZE:0]   wbin_d;
  logic [ADDRSIZE:0]   wptr_d;
  logic                wfull_d;
  logic                walmost_full_d;
  logic [ADDRSIZE:0]   wlevel_d;

  // Synchronised read pointer in binary
  logic [ADDRSIZE:0]   rbin;

  // Widened Gray values: the package helpers work on PTR_W_MAX bits
  logic [PTR_W_MAX-1:0] wgray_ext;
  logic [PTR_W_MAX-1:0] full_tgt_ext;

  gray2bin #(
    .WIDTH (ADDRSIZE + 1)
  ) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  always_comb begin
    wen    = winc & ~wfull_q;
    wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen};

    wgray_ext = bin2gray(PTR_W_MAX'(wbin_d));
    wptr_d    = wgray_ext[ADDRSIZE:0];

    // Full when the next Gray pointer equals the read pointer with its two
    // MSBs inverted, i.e. exactly one lap ahead. Comparing the widened
    // vectors is equivalent since both upper parts are zero.
    full_tgt_ext = PTR_W_MAX'({~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                wq2_rptr[ADDRSIZE-2:0]});
    wfull_d      = (wgray_ext == full_tgt_ext);

    // Modular difference; stale rptr can only make this larger, never
    // smaller, than the true occupancy.
    wlevel_d       = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= afull_thresh);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      wlevel_q       <= '0;
      walmost_full_q <= AFULL_RST;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      wlevel_q       <= wlevel_d;
      walmost_full_q <= walmost_full_d;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  logic wovf_q;
  logic wovf_d;

  always_comb begin
    wovf_d = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign wovf = wovf_q;
`else
  assign wovf = 1'b0;
`endif

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
module tb_wptr_full_lvl;

  localparam int ASZ   = 4;
  localparam int DEPTH = 16;

  logic           wclk = 1'b0;
  logic           wrst_n;
  logic           winc;
  logic [ASZ:0]   wq2_rptr;
  logic [ASZ:0]   afull_thresh;
  logic [ASZ-1:0] waddr;
  logic [ASZ:0]   wptr;
  logic           wfull;
  logic           walmost_full;
  logic [ASZ:0]   wlevel;
  logic           wovf;

  wptr_full_lvl #(
    .ADDRSIZE  (ASZ),
    .AFULL_RST (1'b0)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: total words written / read since reset, as integers.
  int m_wr;
  int m_rd;
  int m_thr;
  bit m_full;
  bit m_af;
  bit m_ovf;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int v);
    return (v ^ (v >> 1)) & 31;
  endfunction

  task automatic chk_all(input string tag);
    int lvl;
    lvl = m_wr - m_rd;
    chk_eq({tag, ".waddr"},  int'(waddr),        m_wr % DEPTH);
    chk_eq({tag, ".wptr"},   int'(wptr),         gray_of(m_wr % (2*DEPTH)));
    chk_eq({tag, ".wfull"},  int'(wfull),        int'(m_full));
    chk_eq({tag, ".wlevel"}, int'(wlevel),       lvl);
    chk_eq({tag, ".afull"},  int'(walmost_full), int'(m_af));
    chk_eq({tag, ".wovf"},   int'(wovf),         int'(m_ovf));
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // One write-clock cycle: drive inputs, take the edge, update model, check.
  task automatic step(input bit w, input int rd, input string tag);
    winc     = w;
    m_rd     = rd;
    wq2_rptr = 5'(gray_of(rd % (2*DEPTH)));
    afull_thresh = 5'(m_thr);
    @(posedge wclk);
`ifdef WPTR_FULL_OVF_EN
    if (w && m_full) m_ovf = 1;
`endif
    if (w && !m_full) m_wr++;
    m_full = ((m_wr - m_rd) == DEPTH);
    m_af   = ((m_wr - m_rd) >= m_thr);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int rd;
    wrst_n = 1'b0; winc = 1'b0; wq2_rptr = '0; afull_thresh = 5'd12;
    m_thr = 12;
    model_reset();
    #2;
    chk_all("reset");
    @(negedge wclk);
    wrst_n = 1'b1;

    // 1: fill from empty, then 4 rejected writes
    for (int i = 0; i < 20; i++) step(1'b1, 0, "fill");
    chk_eq("fill.wptr_full", int'(wptr), 5'b11000);
    chk_eq("fill.level16", int'(wlevel), 16);

    // 2: read of 4 words appears while write pending
    step(1'b1, 4, "unfull");
    chk_eq("unfull.level12", int'(wlevel), 12);
    step(1'b1, 4, "after_unfull");
    chk_eq("after_unfull.level13", int'(wlevel), 13);

    // 3: 40 writes with reader trailing, crosses pointer wrap
    m_thr = 16;
    for (int i = 0; i < 40; i++) step(1'b1, m_wr - 2, "trail");
    chk_eq("trail.level3", int'(wlevel), 3);

    // 4: fill, then write rejected on the edge the read appears
    rd = m_rd;
    while (!m_full) step(1'b1, rd, "fill2");
    step(1'b1, rd + 1, "race");
    chk_eq("race.level15", int'(wlevel), 15);
    step(1'b1, rd + 1, "race_next");

    // 5: reset mid-burst at level 9
    model_reset();
    wrst_n = 1'b0;
    #4;
    chk_all("reset2");
    @(negedge wclk);
    wrst_n = 1'b1;
    m_thr = 12;
    for (int i = 0; i < 9; i++) step(1'b1, 0, "burst");
    #2 wrst_n = 1'b0;
    model_reset();
    #1;
    chk_all("midreset");
    wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 1'b1;
    step(1'b1, 0, "resume");

    // afull_thresh = 0 reads 1 after the first edge
    m_thr = 0;
    step(1'b0, 0, "thr0");

    // Randomised traffic; also exercises overflow attempts while full
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) m_thr = int'($urandom_range(0, DEPTH));
      rd = m_rd;
      if ($urandom_range(0, 2) == 0) rd = rd + int'($urandom_range(1, 3));
      if (rd > m_wr) rd = m_wr;
      step(($urandom_range(0, 3) != 0), rd, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
